uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_pkg.sv | 36 +++
 rtl/uart_cmd_parser_if.sv | 23 ++
 rtl/uart_cmd_parser.sv | 139 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: FSM state encoding,
// ASCII constants recognised by the parser and small byte classifiers.
package uart_cmd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GOT_S = 3'd1,
    ST_DIG1  = 3'd2,
    ST_DIG2  = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  localparam logic [BYTE_W-1:0] ASC_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] ASC_LF    = 8'h0A;
  localparam logic [BYTE_W-1:0] ASC_S_UP  = 8'h53;
  localparam logic [BYTE_W-1:0] ASC_S_LO  = 8'h73;
  localparam logic [BYTE_W-1:0] ASC_PLUS  = 8'h2B;
  localparam logic [BYTE_W-1:0] ASC_MINUS = 8'h2D;
  localparam logic [BYTE_W-1:0] ASC_QUERY = 8'h3F;
  localparam logic [BYTE_W-1:0] ASC_0     = 8'h30;
  localparam logic [BYTE_W-1:0] ASC_1     = 8'h31;
  localparam logic [BYTE_W-1:0] ASC_9     = 8'h39;

  // End of line is either carriage return or line feed.
  function automatic logic is_eol(input logic [BYTE_W-1:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

  // Decimal digit '0'..'9'.
  function automatic logic is_digit(input logic [BYTE_W-1:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / threshold-out bundle around the command parser. The master side
// is the byte source (uart_rx or a bench), the slave side is the parser.
interface uart_cmd_parser_if;
  import uart_cmd_pkg::*;

  logic              recv_en;
  logic [BYTE_W-1:0] recv_data;
  logic [BYTE_W-1:0] temp_thres;
  logic              thres_upd;
  logic              query_req;
  logic              cmd_err;

  modport master (
    output recv_en, recv_data,
    input  temp_thres, thres_upd, query_req, cmd_err
  );

  modport slave (
    input  recv_en, recv_data,
    output temp_thres, thres_upd, query_req, cmd_err
  );

endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII command parser for the temperature threshold. Single-byte commands
// step the threshold or request a status frame; "S<d>[<d>]<EOL>" loads it.
// Malformed lines are flagged once and the rest of the line is dropped; a
// line left idle too long is abandoned.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int THRES_INIT = 40,
  parameter int THRES_MAX  = 80,
  parameter int TIMEOUT_MS = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              recv_en,
  input  logic [BYTE_W-1:0] recv_data,
  output logic [BYTE_W-1:0] temp_thres,
  output logic              thres_upd,
  output logic              query_req,
  output logic              cmd_err
);

  localparam logic [31:0]       GAP_LIMIT = 32'(CLK_FRE * 1000 * TIMEOUT_MS);
  localparam logic [BYTE_W-1:0] MAX_8     = 8'(THRES_MAX);
  localparam logic [BYTE_W-1:0] INIT_8    = 8'(THRES_INIT);

  state_t      state;
  logic        recv_en_p0;
  logic        byte_evt;
  logic [6:0]  acc;
  logic [6:0]  digit;
  logic [31:0] gap;
  logic        timeout;

  // Saturating step up, pinned at the highest legal threshold.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] t);
    return (t >= MAX_8) ? MAX_8 : t + 8'd1;
  endfunction

  // Saturating step down, pinned at zero.
  function automatic logic [BYTE_W-1:0] sat_dec(input logic [BYTE_W-1:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  // A byte is complete when recv_en falls.
  assign byte_evt = recv_en_p0 && !recv_en;
  assign digit    = 7'(recv_data - ASC_0);
  // A byte arriving in the same cycle overrides the timeout.
  assign timeout  = (state != ST_IDLE) && (gap == GAP_LIMIT) && !byte_evt;

  // Delay recv_en by one cycle for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) recv_en_p0 <= 1'b0;
    else        recv_en_p0 <= recv_en;
  end

  // Inter-byte gap counter: cleared by every byte, runs only mid-line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= '0;
    end else if (byte_evt || timeout) begin
      gap <= '0;
    end else if (state != ST_IDLE) begin
      gap <= gap + 32'd1;
    end
  end

  // Parser FSM with threshold register and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      temp_thres <= INIT_8;
      acc        <= '0;
      thres_upd  <= 1'b0;
      query_req  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      thres_upd <= 1'b0;
      query_req <= 1'b0;
      cmd_err   <= 1'b0;
      if (byte_evt) begin
        case (state)
          ST_IDLE: begin
            if (recv_data == ASC_1 || recv_data == ASC_PLUS) begin
              temp_thres <= sat_inc(temp_thres);
              thres_upd  <= 1'b1;
            end else if (recv_data == ASC_0 || recv_data == ASC_MINUS) begin
              temp_thres <= sat_dec(temp_thres);
              thres_upd  <= 1'b1;
            end else if (recv_data == ASC_QUERY) begin
              query_req <= 1'b1;
            end else if (recv_data == ASC_S_UP || recv_data == ASC_S_LO) begin
              state <= ST_GOT_S;
            end else if (!is_eol(recv_data)) begin
              cmd_err <= 1'b1;
            end
          end
          ST_GOT_S: begin
            if (is_digit(recv_data)) begin
              acc   <= digit;
              state <= ST_DIG1;
            end else if (is_eol(recv_data)) begin
              cmd_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              cmd_err <= 1'b1;
              state   <= ST_DROP;
            end
          end
          ST_DIG1, ST_DIG2: begin
            if (is_eol(recv_data)) begin
              if ({1'b0, acc} <= MAX_8) begin
                temp_thres <= {1'b0, acc};
                thres_upd  <= 1'b1;
              end else begin
                cmd_err <= 1'b1;
              end
              state <= ST_IDLE;
            end else if (state == ST_DIG1 && is_digit(recv_data)) begin
              acc   <= 7'(acc * 7'd10 + digit);
              state <= ST_DIG2;
            end else begin
              cmd_err <= 1'b1;
              state   <= ST_DROP;
            end
          end
          ST_DROP: begin
            if (is_eol(recv_data)) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout) begin
        if (state != ST_DROP) cmd_err <= 1'b1;
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised scoreboard bench for uart_cmd_parser with a line-level model.
module tb_uart_cmd_parser;

  localparam int CLK_FRE    = 1;
  localparam int TIMEOUT_MS = 1;
  localparam int THRES_INIT = 40;
  localparam int THRES_MAX  = 80;
  localparam int LIMIT      = CLK_FRE * 1000 * TIMEOUT_MS;

  typedef struct {
    bit upd;
    bit qry;
    bit err;
    int thres;
    int lo;
    int hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_c = 0;
  exp_t q[$];

  // model state: current threshold, pending "S" line, dropping rest of line
  int m_thres;
  bit m_pend;
  bit m_drop;
  int m_ndig;
  int m_val;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .CLK_FRE(CLK_FRE), .THRES_INIT(THRES_INIT),
    .THRES_MAX(THRES_MAX), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .recv_en(bus.recv_en), .recv_data(bus.recv_data),
    .temp_thres(bus.temp_thres), .thres_upd(bus.thres_upd),
    .query_req(bus.query_req), .cmd_err(bus.cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic bit eol(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_thres = THRES_INIT;
    m_pend = 0; m_drop = 0; m_ndig = 0; m_val = 0;
    q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    exp_t e;
    bit push = 0;
    e = '{0, 0, 0, 0, c + 1, c + 1};
    if (m_drop) begin
      if (eol(b)) m_drop = 0;
    end else if (m_pend) begin
      if (eol(b)) begin
        m_pend = 0;
        push = 1;
        if (m_ndig == 0 || m_val > THRES_MAX) e.err = 1;
        else begin m_thres = m_val; e.upd = 1; end
      end else if (b >= "0" && b <= "9" && m_ndig < 2) begin
        m_val = m_val * 10 + int'(b - "0");
        m_ndig++;
      end else begin
        e.err = 1; push = 1; m_pend = 0; m_drop = 1;
      end
    end else begin
      push = 1;
      if (b == "1" || b == "+") begin
        m_thres = (m_thres + 1 > THRES_MAX) ? THRES_MAX : m_thres + 1;
        e.upd = 1;
      end else if (b == "0" || b == "-") begin
        m_thres = (m_thres == 0) ? 0 : m_thres - 1;
        e.upd = 1;
      end else if (b == "?") begin
        e.qry = 1;
      end else if (b == "S" || b == "s") begin
        m_pend = 1; m_ndig = 0; m_val = 0; push = 0;
      end else if (eol(b)) begin
        push = 0;
      end else begin
        e.err = 1;
      end
    end
    e.thres = m_thres;
    if (push) q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.recv_data = b;
    bus.recv_en = 1'b1;
    repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    #1;
    bus.recv_en = 1'b0;
    last_c = cyc;
    model_byte(b, cyc);
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Idle long enough for the line timeout to expire.
  task automatic idle_timeout();
    exp_t e;
    if (m_pend) begin
      e = '{0, 0, 1, m_thres, last_c + LIMIT - 2, last_c + LIMIT + 4};
      q.push_back(e);
    end
    m_pend = 0; m_drop = 0;
    repeat (LIMIT + 20) @(posedge clk);
  endtask

  task automatic settle_and_check(input string name);
    repeat (4) @(negedge clk);
    check({name, "_thres"}, int'(bus.temp_thres), m_thres);
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    bus.recv_en = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check("rst_thres", int'(bus.temp_thres), THRES_INIT);
    check("rst_pulses", int'({bus.thres_upd, bus.query_req, bus.cmd_err}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.thres_upd || bus.query_req || bus.cmd_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cyc=%0d upd=%0b qry=%0b err=%0b thres=%0d, expected no pulse",
                 cyc, bus.thres_upd, bus.query_req, bus.cmd_err, bus.temp_thres);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.thres_upd !== e.upd || bus.query_req !== e.qry || bus.cmd_err !== e.err ||
            int'(bus.temp_thres) != e.thres || cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL response: cyc=%0d upd=%0b qry=%0b err=%0b thres=%0d, expected cyc %0d..%0d upd=%0b qry=%0b err=%0b thres=%0d",
                   cyc, bus.thres_upd, bus.query_req, bus.cmd_err, bus.temp_thres,
                   e.lo, e.hi, e.upd, e.qry, e.err, e.thres);
        end
      end
    end
  end

  initial begin
    logic [7:0] alpha [16];
    alpha = '{"1", "+", "0", "-", "?", "S", "s", 8'h0D, 8'h0A,
              "2", "5", "7", "9", "x", "A", "3"};
    rst_n = 1'b0;
    bus.recv_en = 1'b0;
    bus.recv_data = 8'h00;
    apply_reset();

    send_str("S55\r\n");           settle_and_check("s55");
    check("s55_value", int'(bus.temp_thres), 55);
    send_str("S80\r"); send_byte("1"); send_byte("+");
    settle_and_check("sat_hi");
    send_str("s0\r"); send_byte("-"); send_byte("0");
    settle_and_check("sat_lo");
    send_str("S95\r");             settle_and_check("s95");
    send_str("S123\r");            settle_and_check("s123");
    send_str("S4"); idle_timeout();
    send_str("S7\n");              settle_and_check("timeout_s7");
    check("s7_value", int'(bus.temp_thres), 7);
    send_str("SX5\r");             settle_and_check("drop");
    send_str("S\r");               settle_and_check("s_eol");
    send_str("S12"); send_byte("y"); idle_timeout();
    send_byte("?"); send_byte("x"); settle_and_check("qry_x");
    send_str("S6");
    apply_reset();
    send_byte(8'h0D);              settle_and_check("rst_mid");
    check("rst_mid_value", int'(bus.temp_thres), THRES_INIT);

    for (int n = 0; n < 200; n++) begin
      send_byte(alpha[$urandom_range(0, 15)]);
      if ($urandom_range(0, 39) == 0) idle_timeout();
    end
    send_byte(8'h0D);
    settle_and_check("random");

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
